// File: rtl/ltl_event_arbiter.sv
// ltl_event_arbiter: run-control and violation-event scheduler for one LTL
// monitor cluster.
//   clk, reset                 : clock, synchronous active-high reset
//   enable                     : monitoring enable level
//   sym_valid/sym_ready        : trace symbol handshake, symbols_in = payload
//   mon_run/mon_reset          : cluster run strobe and cluster reset
//   mon_symbols                : symbol pass-through to the cluster
//   ltl_hit, prop_mask         : cluster property outputs and report enables
//   evt_valid/evt_ready        : event FIFO head handshake
//   evt_id, evt_ts             : property index and causing-symbol timestamp
//   busy                       : controller is not idle
module ltl_event_arbiter #(
  parameter int unsigned NUM_PROPS  = 13,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [7:0]           symbols_in,
  output logic                 mon_run,
  output logic                 mon_reset,
  output logic [7:0]           mon_symbols,
  input  logic [NUM_PROPS-1:0] ltl_hit,
  input  logic [NUM_PROPS-1:0] prop_mask,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [ID_WIDTH-1:0]  evt_id,
  output logic [TS_WIDTH-1:0]  evt_ts,
  output logic                 busy
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CAND_W = ID_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 clear_ts;
  logic [NUM_PROPS-1:0] pending_q;
  logic [NUM_PROPS-1:0] masked;
  logic [NUM_PROPS-1:0] grant_mask;
  logic [TS_WIDTH-1:0]  hit_ts_q [NUM_PROPS];
  logic [ID_WIDTH-1:0]  rr_ptr_q;
  logic [TS_WIDTH-1:0]  ts_q;
  logic [TS_WIDTH-1:0]  ts_dly_q;
  logic                 run_d_q;

  logic                 grant_valid;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic [CAND_W-1:0]    cand;

  logic [ID_WIDTH-1:0]  fifo_id_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]  fifo_ts_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 fifo_full;
  logic                 fifo_push, fifo_pop;

  // Hits only mean something in the cycle after an accepted symbol.
  assign masked      = ltl_hit & prop_mask & {NUM_PROPS{run_d_q}};
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign mon_run     = sym_valid & sym_ready;
  assign mon_symbols = symbols_in;

  // Next-state and run-control outputs.
  always_comb begin
    state_d   = state_q;
    sym_ready = 1'b0;
    mon_reset = 1'b0;
    busy      = 1'b1;
    clear_ts  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mon_reset = 1'b1;
        busy      = 1'b0;
        if (enable) begin
          state_d  = ST_RUN;
          clear_ts = 1'b1;
        end
      end
      ST_RUN: begin
        // Stall while any hit is in flight so a new symbol's hits never
        // collide with unreported ones.
        sym_ready = (pending_q == '0) && (masked == '0) && !fifo_full;
        if (!enable) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!run_d_q && (pending_q == '0) && (masked == '0)) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mon_reset = 1'b1;
        busy      = 1'b0;
      end
    endcase
  end

  // Round-robin pick of the first pending bit at or after rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if ((pending_q != '0) && !fifo_full) begin
      for (int unsigned k = 0; k < NUM_PROPS; k++) begin
        cand = {1'b0, rr_ptr_q} + CAND_W'(k);
        if (cand >= CAND_W'(NUM_PROPS)) cand = cand - CAND_W'(NUM_PROPS);
        if (!grant_valid && pending_q[cand[ID_WIDTH-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[ID_WIDTH-1:0];
        end
      end
    end
  end

  assign grant_mask = grant_valid ? (NUM_PROPS'(1) << grant_idx) : '0;
  assign fifo_push  = grant_valid;
  assign fifo_pop   = (count_q != '0) && evt_ready;

  // Control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      ts_q      <= '0;
      ts_dly_q  <= '0;
      run_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_d_q   <= mon_run;
      ts_dly_q  <= ts_q;
      pending_q <= (pending_q & ~grant_mask) | masked;
      if (clear_ts)     ts_q <= '0;
      else if (mon_run) ts_q <= ts_q + TS_WIDTH'(1);
      if (grant_valid) begin
        rr_ptr_q <= (grant_idx == ID_WIDTH'(NUM_PROPS - 1)) ? '0
                                                             : grant_idx + ID_WIDTH'(1);
      end
    end
  end

  // Per-property timestamp of the symbol that caused the hit.
  for (genvar g = 0; g < NUM_PROPS; g++) begin : g_hit_ts
    always_ff @(posedge clk) begin
      if (masked[g]) hit_ts_q[g] <= ts_dly_q;
    end
  end

  // Event FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Event FIFO storage.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_id_q[wr_ptr_q] <= grant_idx;
      fifo_ts_q[wr_ptr_q] <= hit_ts_q[grant_idx];
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_id    = fifo_id_q[rd_ptr_q];
  assign evt_ts    = fifo_ts_q[rd_ptr_q];

endmodule

// File: tb/tb_ltl_event_arbiter.sv
// tb_ltl_event_arbiter: directed bench with a scoreboard of expected events
// {id, ts}; a forked monitor pops and compares on every FIFO handshake.
`timescale 1ns/1ps
module tb_ltl_event_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sym_valid;
  logic        sym_ready;
  logic [7:0]  symbols_in;
  logic        mon_run;
  logic        mon_reset;
  logic [7:0]  mon_symbols;
  logic [12:0] ltl_hit;
  logic [12:0] prop_mask;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_id;
  logic [15:0] evt_ts;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  logic [19:0] sb [$];
  logic        rdy_hit;

  always #5 clk = ~clk;

  ltl_event_arbiter #(
    .NUM_PROPS (13),
    .ID_WIDTH  (4),
    .TS_WIDTH  (16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .symbols_in (symbols_in),
    .mon_run    (mon_run),
    .mon_reset  (mon_reset),
    .mon_symbols(mon_symbols),
    .ltl_hit    (ltl_hit),
    .prop_mask  (prop_mask),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_ts     (evt_ts),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic expect_evt(input logic [3:0] id, input logic [15:0] ts);
    sb.push_back({id, ts});
  endtask

  // Pops the expected queue on every accepted FIFO head.
  task automatic monitor();
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (evt_valid && evt_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL evt_unexpected actual id=%0d ts=0x%0h required=none", evt_id, evt_ts);
        end else begin
          e = sb.pop_front();
          check("evt_id", 32'(evt_id), 32'(e[19:16]));
          check("evt_ts", 32'(evt_ts), 32'(e[15:0]));
        end
      end
    end
  endtask

  // One symbol, then drive its hit vector in the following cycle.
  task automatic send_sym(input logic [12:0] hits, input bit drop_en, output logic rdy);
    int n = 0;
    sym_valid = 1'b1;
    @(negedge clk);
    while (!mon_run && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sym_accept", 32'(mon_run), 1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    ltl_hit   = hits;
    if (drop_en) enable = 1'b0;
    @(negedge clk);
    rdy = sym_ready;
    @(posedge clk); #1;
    ltl_hit = '0;
  endtask

  // Back-to-back hit-free symbols.
  task automatic stream(input int n_sym);
    int acc = 0;
    int cyc = 0;
    sym_valid = 1'b1;
    while (acc < n_sym && cyc < n_sym + 50) begin
      @(negedge clk);
      cyc++;
      if (mon_run) acc++;
    end
    check("stream_count", acc, n_sym);
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    sym_valid  = 1'b1;
    symbols_in = 8'hA5;
    ltl_hit    = '0;
    prop_mask  = 13'h1FFF;
    evt_ready  = 1'b1;
    fork
      monitor();
    join_none

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sym_ready", 32'(sym_ready), 0);
    check("rst_mon_run",   32'(mon_run),   0);
    check("rst_mon_reset", 32'(mon_reset), 1);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_busy",      32'(busy),      0);

    // Start-up: one IDLE cycle, then a symbol every cycle.
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_mon_reset", 32'(mon_reset), 1);
    check("idle_sym_ready", 32'(sym_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("run_mon_run",   32'(mon_run),   1);
      check("run_mon_reset", 32'(mon_reset), 0);
    end
    check("mon_symbols", 32'(mon_symbols), 32'hA5);
    @(posedge clk); #1;
    sym_valid = 1'b0;

    // Five symbols consumed, so the next one carries ts=5.
    expect_evt(4'd1, 16'd5);
    send_sym(13'h0002, 1'b0, rdy_hit);
    wait_drain(20);

    // Leave an event in the FIFO, then reset mid-stream: it is discarded.
    evt_ready = 1'b0;
    send_sym(13'h0010, 1'b0, rdy_hit);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_evt_valid", 32'(evt_valid), 1);
    @(posedge clk); #1;
    sym_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_sym_ready", 32'(sym_ready), 0);
    check("midrst_mon_run",   32'(mon_run),   0);
    check("midrst_mon_reset", 32'(mon_reset), 1);
    check("midrst_evt_valid", 32'(evt_valid), 0);
    check("midrst_busy",      32'(busy),      0);
    @(posedge clk); #1;
    reset     = 1'b0;
    sym_valid = 1'b0;
    evt_ready = 1'b1;

    // Single hit on bit 3 for the symbol with ts=7.
    stream(7);
    expect_evt(4'd3, 16'd7);
    send_sym(13'h0008, 1'b0, rdy_hit);
    check("hit_cycle_sym_ready", 32'(rdy_hit), 0);
    @(negedge clk);
    check("grant_cycle_evt_valid", 32'(evt_valid), 0);
    check("grant_cycle_sym_ready", 32'(sym_ready), 0);
    @(negedge clk);
    check("post_grant_evt_valid", 32'(evt_valid), 1);
    check("post_grant_sym_ready", 32'(sym_ready), 1);
    wait_drain(20);

    // Round-robin: move rr_ptr to 6, then hits on 0,5,12 and on 5,6.
    expect_evt(4'd5, 16'd8);
    send_sym(13'h0020, 1'b0, rdy_hit);
    expect_evt(4'd12, 16'd9);
    expect_evt(4'd0,  16'd9);
    expect_evt(4'd5,  16'd9);
    send_sym(13'h1021, 1'b0, rdy_hit);
    expect_evt(4'd6, 16'd10);
    expect_evt(4'd5, 16'd10);
    send_sym(13'h0060, 1'b0, rdy_hit);
    wait_drain(40);

    // FIFO full: six events with the reader stalled, two left pending.
    evt_ready = 1'b0;
    expect_evt(4'd7, 16'd11);
    send_sym(13'h0080, 1'b0, rdy_hit);
    expect_evt(4'd8, 16'd12);
    send_sym(13'h0100, 1'b0, rdy_hit);
    expect_evt(4'd9, 16'd13);
    send_sym(13'h0200, 1'b0, rdy_hit);
    expect_evt(4'd10, 16'd14);
    expect_evt(4'd11, 16'd14);
    expect_evt(4'd1,  16'd14);
    send_sym(13'h0C02, 1'b0, rdy_hit);
    sym_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_sym_ready", 32'(sym_ready), 0);
      check("full_mon_run",   32'(mon_run),   0);
    end
    check("full_evt_valid", 32'(evt_valid), 1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    evt_ready = 1'b1;
    wait_drain(60);

    // Masked property: no event and no stall.
    prop_mask = 13'h1FFB;
    send_sym(13'h0004, 1'b0, rdy_hit);
    check("masked_sym_ready", 32'(rdy_hit), 1);
    @(negedge clk);
    @(negedge clk);
    check("masked_evt_valid", 32'(evt_valid), 0);
    @(posedge clk); #1;
    prop_mask = 13'h1FFF;

    // Timestamp wrap: ts is 16 here, advance to 0xFFFF.
    stream(65519);
    expect_evt(4'd4, 16'hFFFF);
    send_sym(13'h0010, 1'b0, rdy_hit);
    expect_evt(4'd4, 16'h0000);
    send_sym(13'h0010, 1'b0, rdy_hit);
    wait_drain(40);

    // Disable in the hit cycle: flush, push, then idle with event held.
    evt_ready = 1'b0;
    expect_evt(4'd9, 16'd1);
    send_sym(13'h0200, 1'b1, rdy_hit);
    @(negedge clk);
    check("flush_busy",      32'(busy),      1);
    check("flush_mon_reset", 32'(mon_reset), 0);
    check("flush_sym_ready", 32'(sym_ready), 0);
    check("flush_evt_valid", 32'(evt_valid), 0);
    @(negedge clk);
    check("flush2_evt_valid", 32'(evt_valid), 1);
    check("flush2_busy",      32'(busy),      1);
    @(negedge clk);
    check("idle_after_mon_reset", 32'(mon_reset), 1);
    check("idle_after_busy",      32'(busy),      0);
    check("idle_after_evt_valid", 32'(evt_valid), 1);
    repeat (3) @(negedge clk);
    check("idle_hold_evt_valid", 32'(evt_valid), 1);
    @(posedge clk); #1;
    evt_ready = 1'b1;
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
